// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the execute-stage ALU-op to muldiv-op mapping.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MULDIV_MULT  = 2'd0,
        MULDIV_MULTU = 2'd1,
        MULDIV_DIV   = 2'd2,
        MULDIV_DIVU  = 2'd3
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } muldiv_state_e;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    function automatic muldiv_op_e exe_to_op(input logic [7:0] aluop);
        case (aluop)
            EXE_MULTU_OP: return MULDIV_MULTU;
            EXE_DIV_OP:   return MULDIV_DIV;
            EXE_DIVU_OP:  return MULDIV_DIVU;
            default:      return MULDIV_MULT;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage to muldiv handshake: request/flush in, stall/done/HI-LO out.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             flush;
    logic             arith_stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             whilo_out;

    modport master (
        output start, op, src1, src2, flush,
        input  arith_stall, busy, done, hi_out, lo_out, whilo_out
    );

    modport slave (
        input  start, op, src1, src2, flush,
        output arith_stall, busy, done, hi_out, lo_out, whilo_out
    );
endinterface

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per
// step, MSB first. A zero divisor yields quotient all ones, remainder = dividend.
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    // The quotient register doubles as the dividend shifter: its MSB feeds
    // the partial remainder while quotient bits enter at the LSB.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};

    // NOTE: every register here is reset, including the datapath, so an
    // aborted operation never leaks stale operands into the next one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= rem_shift[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with start/done handshake and HI/LO results.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (DIV stays iterative).
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    muldiv_unit_if.slave  bus
);
    localparam int PW = 2 * WIDTH;

    muldiv_state_e    state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             div_q;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH-1:0] mcand;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             accept;
    logic             last_step;
    logic             op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] quo, rem;
    logic [PW-1:0]    prod_fin;
    logic [WIDTH-1:0] hi_fin, lo_fin;

    assign accept    = (state == ST_IDLE) && bus.start && !bus.flush;
    assign last_step = (cnt == CNT_W'(1));
    assign op_signed = !bus.op[0];
    assign a_neg     = op_signed && bus.src1[WIDTH-1];
    assign b_neg     = op_signed && bus.src2[WIDTH-1];
    assign abs_a     = a_neg ? -bus.src1 : bus.src1;
    assign abs_b     = b_neg ? -bus.src2 : bus.src2;

    muldiv_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rstn      (rstn),
        .load      (accept && bus.op[1]),
        .step      (state == ST_DIV),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (quo),
        .remainder (rem)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: defaulting state_nxt first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) state_nxt = bus.op[1] ? ST_DIV : ST_MUL;
`ifdef MULDIV_FAST_MUL_EN
                ST_MUL:  state_nxt = ST_FIN;
`else
                ST_MUL:  if (last_step) state_nxt = ST_FIN;
`endif
                ST_DIV:  if (last_step) state_nxt = ST_FIN;
                ST_FIN:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

`ifndef MULDIV_FAST_MUL_EN
    // Shift-add step: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            div_q  <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (accept) begin
                cnt    <= CNT_W'(WIDTH);
                div_q  <= bus.op[1];
                sign_q <= a_neg ^ b_neg;
                sign_r <= a_neg;
                mcand  <= abs_a;
                acc    <= {{WIDTH{1'b0}}, abs_b};
            end else if (state == ST_MUL) begin
                cnt <= cnt - CNT_W'(1);
`ifdef MULDIV_FAST_MUL_EN
                acc <= PW'(mcand) * PW'(acc[WIDTH-1:0]);
`else
                acc <= {mul_sum, acc[WIDTH-1:1]};
`endif
            end else if (state == ST_DIV) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (state == ST_FIN && !bus.flush) begin
                hi_q <= hi_fin;
                lo_q <= lo_fin;
            end
        end
    end

    // Sign correction on the unsigned magnitudes produced by either datapath.
    always_comb begin
        prod_fin = sign_q ? -acc : acc;
        if (div_q) begin
            hi_fin = sign_r ? -rem : rem;
            lo_fin = sign_q ? -quo : quo;
        end else begin
            hi_fin = prod_fin[PW-1:WIDTH];
            lo_fin = prod_fin[WIDTH-1:0];
        end
    end

    // Results are presented combinationally in the FIN cycle so done and HI/LO
    // arrive together; the registered copy holds them until the next done.
    always_comb begin
        bus.busy        = (state != ST_IDLE);
        bus.arith_stall = (bus.start && state == ST_IDLE)
                          || state == ST_MUL || state == ST_DIV;
        bus.done        = (state == ST_FIN) && !bus.flush;
        bus.whilo_out   = bus.done;
        bus.hi_out      = bus.done ? hi_fin : hi_q;
        bus.lo_out      = bus.done ? lo_fin : lo_q;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: arithmetic results, latency, stall,
// flush, ignored start while busy and asynchronous reset mid-operation.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_bad;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts an op at cycle 0 (caller sits just after a rising edge) and checks
    // latency, stall profile, results, the one-cycle done pulse and the hold.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input int exp_lat);
        int c;
        bit stall_ok;
        bus.start = 1'b1;
        bus.op    = o;
        bus.src1  = a;
        bus.src2  = b;
        #1;
        check({tag, "_stall_c0"}, 64'(bus.arith_stall), 64'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        c = 1;
        stall_ok = 1'b1;
        while (!bus.done && c < 200) begin
            if (!bus.arith_stall || !bus.busy) stall_ok = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        check({tag, "_latency"}, 64'(c), 64'(exp_lat));
        check({tag, "_stall_run"}, 64'(stall_ok), 64'd1);
        check({tag, "_stall_fin"}, 64'(bus.arith_stall), 64'd0);
        check({tag, "_whilo"}, 64'(bus.whilo_out), 64'd1);
        check({tag, "_hi"}, 64'(bus.hi_out), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo_out), 64'(exp_lo));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {62'd0, bus.done, bus.whilo_out}, 64'd0);
        check({tag, "_hold"}, {bus.hi_out, bus.lo_out}, {exp_hi, exp_lo});
    endtask

    initial begin
        int c;
        bit saw_done;
        logic [1:0] rst_op;
        n_vec = 0;
        n_bad = 0;
        rstn = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.src1  = '0;
        bus.src2  = '0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {60'd0, bus.busy, bus.done, bus.whilo_out, bus.arith_stall}, 64'd0);
        check("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        run_op("mult_neg",  2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
        run_op("div_neg",   2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("divu_100_7",2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT);
        run_op("divu_by0",  2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV_LAT);
        run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LAT);

        // Flush at cycle 10 of a DIV: no done, HI/LO keep the div_ovf result.
        bus.start = 1'b1; bus.op = 2'd2; bus.src1 = 32'hFFFF_FFF9; bus.src2 = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c = 1;
        saw_done = 1'b0;
        while (c < 10) begin
            if (bus.done) saw_done = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        bus.flush = 1'b1;
        #1;
        if (bus.done) saw_done = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_hilo", {bus.hi_out, bus.lo_out}, {32'd0, 32'h8000_0000});
        @(posedge clk); #1;
        if (bus.done) saw_done = 1'b1;
        check("flush_no_done", 64'(saw_done), 64'd0);
        run_op("after_flush", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);

        // A second start at cycle 3 must neither restart nor re-sample operands.
        bus.start = 1'b1; bus.op = 2'd3; bus.src1 = 32'd1000; bus.src2 = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c = 1;
        while (c < 3) begin
            @(posedge clk); #1;
            c++;
        end
        bus.start = 1'b1; bus.op = 2'd1; bus.src1 = 32'd6; bus.src2 = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c++;
        while (!bus.done && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("ignore_latency", 64'(c), 64'(DIV_LAT));
        check("ignore_result", {bus.hi_out, bus.lo_out}, {32'd6, 32'd142});
        @(posedge clk); #1;
        check("ignore_idle", 64'(bus.busy), 64'd0);

        run_op("multu_6x7", 2'd1, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);

        // Asynchronous reset at cycle 5 of a long operation.
`ifdef MULDIV_FAST_MUL_EN
        rst_op = 2'd3;
`else
        rst_op = 2'd1;
`endif
        bus.start = 1'b1; bus.op = rst_op; bus.src1 = 32'hFFFF_FFFF; bus.src2 = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c = 1;
        while (c < 5) begin
            @(posedge clk); #1;
            c++;
        end
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        rstn = 1'b0;
        #1;
        check("midrst_ctrl", {60'd0, bus.busy, bus.done, bus.whilo_out, bus.arith_stall}, 64'd0);
        check("midrst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", {62'd0, bus.busy, bus.done}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
